load_data_ctrl: RTL and testbench

LOAD_DATA_CTRL -- requirements
Module: load_data_ctrl

---
 rtl/load_data_ctrl.sv | 155 +++++++++++++++
 tb/tb_load_data_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_data_ctrl.sv
// Load data controller: decodes the load region, sequences DMEM and I/O reads,
// and aligns/extends the returned data to a 32-bit big-endian load result.
module load_data_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  input  logic        stall,
  input  logic [31:0] addr,
  input  logic [5:0]  opcode,
  input  logic [31:0] dmem_dout,
  input  logic [31:0] io_rdata,
  input  logic        io_rvalid,
  output logic        io_rd_req,
  output logic        load_stall,
  output logic [31:0] ld_data,
  output logic        ld_data_valid,
  output logic        ld_err
);

  // state     | meaning
  // S_IDLE    | no load in flight
  // S_DATA    | DMEM/unmapped result presented this cycle
  // S_IO_WAIT | I/O read outstanding, pipeline stalled, timeout running
  // S_IO_DONE | I/O result (or timeout error) presented this cycle

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_IO_WAIT, S_IO_DONE} state_t;
  typedef enum logic [1:0] {R_UNMAPPED, R_DMEM, R_IO} region_t;

  state_t      state_q, state_d;
  region_t     region_in, region_q;
  logic [5:0]  op_q;
  logic [1:0]  off_q;
  logic        err_q;
  logic [31:0] data_q;
  logic        dmem_held_q;
  logic [7:0]  cnt_q;

  logic        is_load;
  logic        accept;
  logic        out_valid;
  logic [31:0] raw_data;
  logic        unused_addr;

  assign unused_addr = ^{addr[30:29], addr[27:2]};

  function automatic logic [31:0] align_load(input logic [5:0]  op,
                                             input logic [1:0]  off,
                                             input logic [31:0] raw);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'b00:   b = raw[31:24];
      2'b01:   b = raw[23:16];
      2'b10:   b = raw[15:8];
      default: b = raw[7:0];
    endcase
    h = off[1] ? raw[15:0] : raw[31:16];
    case (op)
      OP_LB:   res = {{24{b[7]}}, b};
      OP_LBU:  res = {24'h000000, b};
      OP_LH:   res = {{16{h[15]}}, h};
      OP_LHU:  res = {16'h0000, h};
      default: res = raw;
    endcase
    return res;
  endfunction

  always_comb begin
    is_load = (opcode == OP_LB) || (opcode == OP_LH) || (opcode == OP_LW) ||
              (opcode == OP_LBU) || (opcode == OP_LHU);
    if (addr[31])      region_in = R_IO;
    else if (addr[28]) region_in = R_DMEM;
    else               region_in = R_UNMAPPED;
    accept = !rst && ld_valid && !stall && is_load && (state_q != S_IO_WAIT);
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = (region_in == R_IO) ? S_IO_WAIT : S_DATA;
    end else begin
      case (state_q)
        S_DATA, S_IO_DONE: if (!stall) state_d = S_IDLE;
        S_IO_WAIT:         if (io_rvalid || cnt_q == 8'hFF) state_d = S_IO_DONE;
        default:           state_d = S_IDLE;
      endcase
    end
  end

  // DMEM data is live only in the first DATA cycle; a stall captures it so the
  // result stays stable however long the pipeline is frozen.
  always_comb begin
    out_valid     = !rst && (state_q == S_DATA || state_q == S_IO_DONE);
    raw_data      = (state_q == S_DATA && region_q == R_DMEM && !dmem_held_q) ?
                    dmem_dout : data_q;
    io_rd_req     = accept && (region_in == R_IO);
    load_stall    = !rst && (state_q == S_IO_WAIT);
    ld_data_valid = out_valid;
    ld_data       = out_valid ? align_load(op_q, off_q, raw_data) : 32'h0;
    ld_err        = out_valid && err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      region_q    <= R_UNMAPPED;
      op_q        <= 6'h0;
      off_q       <= 2'b00;
      err_q       <= 1'b0;
      data_q      <= 32'h0;
      dmem_held_q <= 1'b0;
      cnt_q       <= 8'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        region_q    <= region_in;
        op_q        <= opcode;
        off_q       <= addr[1:0];
        err_q       <= (region_in == R_UNMAPPED);
        data_q      <= 32'h0;
        dmem_held_q <= 1'b0;
        cnt_q       <= 8'h0;
      end else begin
        case (state_q)
          S_IO_WAIT: begin
            if (io_rvalid) begin
              data_q <= io_rdata;
              err_q  <= 1'b0;
            end else if (cnt_q == 8'hFF) begin
              data_q <= 32'h0;
              err_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          S_DATA: begin
            if (stall && region_q == R_DMEM && !dmem_held_q) begin
              data_q      <= dmem_dout;
              dmem_held_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_load_data_ctrl.sv
// Bench for load_data_ctrl: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level model of the load rules.
module tb_load_data_ctrl;

  logic        clk;
  logic        rst;
  logic        ld_valid;
  logic        stall;
  logic [31:0] addr;
  logic [5:0]  opcode;
  logic [31:0] dmem_dout;
  logic [31:0] io_rdata;
  logic        io_rvalid;
  logic        io_rd_req;
  logic        load_stall;
  logic [31:0] ld_data;
  logic        ld_data_valid;
  logic        ld_err;

  load_data_ctrl dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .stall(stall), .addr(addr),
    .opcode(opcode), .dmem_dout(dmem_dout), .io_rdata(io_rdata),
    .io_rvalid(io_rvalid), .io_rd_req(io_rd_req), .load_stall(load_stall),
    .ld_data(ld_data), .ld_data_valid(ld_data_valid), .ld_err(ld_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Model: no transaction (0), result being presented (1), I/O outstanding (2)
  int          m_kind = 0;
  int          m_wait = 0;
  logic [5:0]  m_op   = 6'h0;
  logic [1:0]  m_off  = 2'b00;
  logic        m_err  = 1'b0;
  logic        m_live = 1'b0;
  logic [31:0] m_raw  = 32'h0;

  logic [31:0] s_data;
  logic        s_valid, s_err, s_stall, s_req;

  logic [5:0] op_tab [7] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h00, 6'h2B};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic bit m_is_load(input logic [5:0] op);
    return op == 6'h20 || op == 6'h21 || op == 6'h23 || op == 6'h24 || op == 6'h25;
  endfunction

  function automatic int m_region(input logic [31:0] a);
    if (a[31]) return 2;
    if (a[28]) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] m_align(input logic [5:0] op, input logic [1:0] off,
                                          input logic [31:0] raw);
    logic [31:0] b, h;
    b = (raw >> (8 * (3 - int'(off)))) & 32'hFF;
    h = (raw >> (16 * (1 - int'(off[1])))) & 32'hFFFF;
    case (op)
      6'h20: return (b >= 32'h80) ? b + 32'hFFFFFF00 : b;
      6'h24: return b;
      6'h21: return (h >= 32'h8000) ? h + 32'hFFFF0000 : h;
      6'h25: return h;
      default: return raw;
    endcase
  endfunction

  // One clock: predict outputs from model + current inputs, compare at negedge,
  // then advance the model with the inputs the DUT saw at the rising edge.
  task automatic step();
    logic        acc, e_valid, e_err, e_stall, e_req;
    logic [31:0] e_data;
    int          rg;
    rg      = m_region(addr);
    acc     = !rst && ld_valid && !stall && m_is_load(opcode) && m_kind != 2;
    e_req   = acc && rg == 2;
    e_stall = !rst && m_kind == 2;
    e_valid = !rst && m_kind == 1;
    e_err   = e_valid && m_err;
    e_data  = e_valid ? m_align(m_op, m_off, m_live ? dmem_dout : m_raw) : 32'h0;
    @(negedge clk);
    s_data = ld_data; s_valid = ld_data_valid; s_err = ld_err;
    s_stall = load_stall; s_req = io_rd_req;
    chk("io_rd_req", {31'b0, io_rd_req}, {31'b0, e_req});
    chk("load_stall", {31'b0, load_stall}, {31'b0, e_stall});
    chk("ld_data_valid", {31'b0, ld_data_valid}, {31'b0, e_valid});
    chk("ld_err", {31'b0, ld_err}, {31'b0, e_err});
    chk("ld_data", ld_data, e_data);
    @(posedge clk);
    if (rst) begin
      m_kind = 0;
    end else if (m_kind == 2) begin
      if (io_rvalid) begin
        m_kind = 1; m_live = 0; m_raw = io_rdata; m_err = 0;
      end else if (m_wait == 255) begin
        m_kind = 1; m_live = 0; m_raw = 0; m_err = 1;
      end else begin
        m_wait++;
      end
    end else if (acc) begin
      m_op = opcode; m_off = addr[1:0];
      if (rg == 2) begin
        m_kind = 2; m_wait = 0;
      end else begin
        m_kind = 1; m_live = (rg == 1); m_raw = 0; m_err = (rg == 0);
      end
    end else if (m_kind == 1 && stall) begin
      if (m_live) begin m_raw = dmem_dout; m_live = 0; end
    end else begin
      m_kind = 0;
    end
    #1;
  endtask

  task automatic quiet();
    ld_valid = 0; stall = 0; io_rvalid = 0; rst = 0;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] a);
    ld_valid = 1; opcode = op; addr = a; stall = 0;
  endtask

  initial begin
    int cnt;
    rst = 1; ld_valid = 0; stall = 0; addr = 0; opcode = 0;
    dmem_dout = 0; io_rdata = 0; io_rvalid = 0;
    @(posedge clk); #1;
    ld_valid = 1; opcode = 6'h23; addr = 32'h8000_0000;
    step();
    chk("reset_io_rd_req", {31'b0, s_req}, 32'h0);
    chk("reset_ld_data", s_data, 32'h0);
    quiet(); step();

    // LB byte lane 01, negative byte
    issue(6'h20, 32'h1000_0001); step();
    chk("lb_req", {31'b0, s_req}, 32'h0);
    quiet(); dmem_dout = 32'h12F4_5678; step();
    chk("lb_data", s_data, 32'hFFFF_FFF4);
    chk("lb_valid", {31'b0, s_valid}, 32'h1);
    step();

    // LHU then LW back-to-back
    issue(6'h25, 32'h1000_0002); step();
    issue(6'h23, 32'h1000_0004); dmem_dout = 32'hAAAA_8001; step();
    chk("lhu_data", s_data, 32'h0000_8001);
    quiet(); dmem_dout = 32'hDEAD_BEEF; step();
    chk("lw_data", s_data, 32'hDEAD_BEEF);
    chk("lw_valid", {31'b0, s_valid}, 32'h1);
    step();

    // I/O load completing in the sixth wait cycle
    issue(6'h23, 32'h8000_0008); step();
    chk("io_req_pulse", {31'b0, s_req}, 32'h1);
    quiet(); stall = 1; io_rdata = 32'h0000_004B; cnt = 0;
    for (int i = 0; i < 6; i++) begin
      io_rvalid = (i == 5); step();
      if (s_stall) cnt++;
    end
    chk("io_stall_cycles", cnt, 6);
    quiet(); io_rdata = 32'h1234_5678; step();
    chk("io_data", s_data, 32'h0000_004B);
    chk("io_err", {31'b0, s_err}, 32'h0);
    step();
    chk("io_valid_after", {31'b0, s_valid}, 32'h0);

    // I/O timeout
    issue(6'h23, 32'h8000_0000); step();
    quiet(); stall = 1; cnt = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (s_stall) cnt++;
    end
    chk("timeout_stall_cycles", cnt, 256);
    quiet(); step();
    chk("timeout_data", s_data, 32'h0);
    chk("timeout_err", {31'b0, s_err}, 32'h1);
    chk("timeout_valid", {31'b0, s_valid}, 32'h1);
    step();

    // Unmapped LH
    issue(6'h21, 32'h4000_0000); step();
    quiet(); step();
    chk("unmapped_err", {31'b0, s_err}, 32'h1);
    chk("unmapped_valid", {31'b0, s_valid}, 32'h1);
    chk("unmapped_data", s_data, 32'h0);
    step();

    // Stalled DMEM result holds while dmem_dout changes
    issue(6'h24, 32'h1000_0003); step();
    quiet(); stall = 1; dmem_dout = 32'h0000_00A5; step();
    dmem_dout = 32'hFFFF_FFFF; step();
    chk("stall_hold_data", s_data, 32'h0000_00A5);
    stall = 0; step();
    chk("stall_release_data", s_data, 32'h0000_00A5);
    step();

    // Reset during I/O wait, then a late completion
    issue(6'h21, 32'h8000_0002); step();
    quiet(); stall = 1;
    for (int i = 0; i < 3; i++) step();
    rst = 1; step();
    rst = 0; stall = 0; io_rvalid = 1; io_rdata = 32'hCAFE_F00D; step();
    chk("abandon_stall", {31'b0, s_stall}, 32'h0);
    io_rvalid = 0; step();
    chk("abandon_valid", {31'b0, s_valid}, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      rst       = ($urandom_range(0, 249) == 0);
      ld_valid  = $urandom_range(0, 1);
      stall     = ($urandom_range(0, 4) == 0);
      opcode    = op_tab[$urandom_range(0, 6)];
      r         = $urandom_range(0, 2);
      addr      = $urandom;
      if (r == 0)      addr[31] = 1'b1;
      else if (r == 1) begin addr[31] = 1'b0; addr[28] = 1'b1; end
      else             begin addr[31] = 1'b0; addr[28] = 1'b0; end
      dmem_dout = $urandom;
      io_rdata  = $urandom;
      io_rvalid = ($urandom_range(0, 11) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
